// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and leading-zero helper for the digit scanner
//
// Purpose : defaults for the scanner parameters and lz_mask(), which turns a
//           packed hex value into a per-digit "blank this digit" vector.
// Ports   : none (package).
package seg_pkg;

    localparam int DEFAULT_DIGITS      = 4;
    localparam int DEFAULT_REFRESH_DIV = 50000;
    localparam int MAX_DIGITS          = 8;

    // Bit i is set when digit i and every digit above it (up to n-1) are zero.
    // Digit 0 is never blanked so a zero value still shows a single "0".
    // The value is zero-extended to MAX_DIGITS nibbles by the caller.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] value,
                                                      input int n);
        logic [MAX_DIGITS-1:0] mask;
        logic                  zeroSoFar;
        mask      = '0;
        zeroSoFar = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                zeroSoFar = zeroSoFar && (value[4*i +: 4] == 4'h0);
                mask[i]   = zeroSoFar;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// rtl/seven_seg_scanner_if.sv - value/control in, scan outputs out, bundled
//
// Purpose : groups the scanner's data and display signals.
// Ports   : value_in, load, blank_lz, dp_in       (master -> slave)
//           digit_nibble, digit_blank, anode_n,
//           dp_n, pending, frame_tick            (slave -> master)
interface seven_seg_scanner_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_DIGITS
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [3:0]              digit_nibble;
    logic                    digit_blank;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    dp_n;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output value_in, load, blank_lz, dp_in,
        input  digit_nibble, digit_blank, anode_n, dp_n, pending, frame_tick
    );

    modport slave (
        input  value_in, load, blank_lz, dp_in,
        output digit_nibble, digit_blank, anode_n, dp_n, pending, frame_tick
    );
endinterface

// File: rtl/seg_prescaler.sv
// rtl/seg_prescaler.sv - slot counter (cnt) and digit index (idx) with wrap flags
//
// Purpose : cnt runs 0..REFRESH_DIV-1 every cycle; idx advances on each cnt wrap
//           and wraps after NUM_DIGITS-1.
// Ports   : clk, rst_n (sync active-low)
//           idx       current digit index
//           cntZero   first cycle of a digit slot (anti-ghosting gap)
//           frameEnd  last cycle of the last digit slot
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
    localparam int CNT_W      = $clog2(REFRESH_DIV),
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             cntZero,
    output logic             frameEnd
);
    logic [CNT_W-1:0] cnt;
    logic             slotEnd;
    logic             lastDigit;

    assign slotEnd   = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign lastDigit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign cntZero   = (cnt == '0);
    assign frameEnd  = slotEnd && lastDigit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slotEnd) begin
            cnt <= '0;
            idx <= lastDigit ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - double-buffered multi-digit hex scanner
//
// Purpose : holds a hex value, presents one nibble per digit slot with the
//           matching active-low anode, blanks leading zeros and inserts a
//           one-cycle dark gap at each digit change. New values wait in a
//           shadow register and are applied only at the frame boundary.
// Ports   : clk, rst_n (sync active-low)
//           bus       seven_seg_scanner_if.slave (value/load/blank_lz/dp_in in,
//                     digit_nibble/digit_blank/anode_n/dp_n/pending/frame_tick out)
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEFAULT_DIGITS,
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [IDX_W-1:0]      idx;
    logic                  cntZero;
    logic                  frameEnd;
    logic [VAL_W-1:0]      shadow;
    logic [VAL_W-1:0]      disp;
    logic                  pendingReg;
    logic [MAX_DIGITS-1:0] blankVec;

    seg_prescaler #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx     (idx),
        .cntZero (cntZero),
        .frameEnd(frameEnd)
    );

    // A load landing on the boundary bypasses the shadow wait: the newest
    // value wins and nothing is left pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow     <= '0;
            disp       <= '0;
            pendingReg <= 1'b0;
        end else if (bus.load && frameEnd) begin
            shadow     <= bus.value_in;
            disp       <= bus.value_in;
            pendingReg <= 1'b0;
        end else if (bus.load) begin
            shadow     <= bus.value_in;
            pendingReg <= 1'b1;
        end else if (frameEnd && pendingReg) begin
            disp       <= shadow;
            pendingReg <= 1'b0;
        end
    end

    assign blankVec = lz_mask((4*MAX_DIGITS)'(disp), NUM_DIGITS);

    assign bus.digit_nibble = disp[{idx, 2'b00} +: 4];
    assign bus.anode_n      = cntZero ? '1 : ~(NUM_DIGITS'(1) << idx);
    assign bus.dp_n         = cntZero | ~bus.dp_in[idx];
    assign bus.digit_blank  = cntZero | (bus.blank_lz & blankVec[idx]);
    assign bus.pending      = pendingReg;
    assign bus.frame_tick   = frameEnd;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed and random checks of the digit scanner
module tb_seven_seg_scanner;
    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // reference state: cycles since reset, displayed / shadow value, pending
    int          mTime;
    logic [15:0] mDisp;
    logic [15:0] mShadow;
    logic        mPending;

    logic [3:0] nibSeq [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
    logic [3:0] anSeq  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int   p, c, d;
        logic [3:0] expAn;
        logic [3:0] expNib;
        logic       expBlank, expDp;
        p        = mTime % FRAME;
        c        = p % RD;
        d        = p / RD;
        expAn    = (c == 0) ? 4'hF : ~(4'b0001 << d);
        expNib   = 4'((mDisp >> (4 * d)) & 16'hF);
        expBlank = (c == 0) || (bus.blank_lz && d != 0 && (mDisp >> (4 * d)) == 16'h0);
        expDp    = (c == 0) ? 1'b1 : !bus.dp_in[d];
        chk("anode_n", 32'(bus.anode_n), 32'(expAn));
        chk("digit_nibble", 32'(bus.digit_nibble), 32'(expNib));
        chk("digit_blank", 32'(bus.digit_blank), 32'(expBlank));
        chk("dp_n", 32'(bus.dp_n), 32'(expDp));
        chk("pending", 32'(bus.pending), 32'(mPending));
        chk("frame_tick", 32'(bus.frame_tick), 32'(p == FRAME - 1));
    endtask

    task automatic cycle();
        bit bnd;
        @(posedge clk);
        if (!rst_n) begin
            mTime = 0; mDisp = '0; mShadow = '0; mPending = 1'b0;
        end else begin
            bnd = (mTime % FRAME) == FRAME - 1;
            if (bus.load) begin
                mShadow = bus.value_in;
                if (bnd) begin mDisp = bus.value_in; mPending = 1'b0; end
                else mPending = 1'b1;
            end else if (bnd && mPending) begin
                mDisp = mShadow; mPending = 1'b0;
            end
            mTime++;
        end
        #1;
        check_all();
    endtask

    task automatic wait_tick();
        int k = 0;
        while (bus.frame_tick !== 1'b1 && k < 3 * FRAME) begin
            cycle();
            k++;
        end
        chk("wait_tick_timeout", 32'(bus.frame_tick), 32'd1);
    endtask

    task automatic load_now(input logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        cycle();
        bus.load     = 1'b0;
    endtask

    initial begin
        mTime = 0; mDisp = '0; mShadow = '0; mPending = 1'b0;
        rst_n        = 1'b0;
        bus.value_in = 16'hFFFF;
        bus.load     = 1'b1;
        bus.blank_lz = 1'b0;
        bus.dp_in    = '0;

        // 1: reset (load ignored) and release
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_anode", 32'(bus.anode_n), 32'hF);
            chk("rst_blank", 32'(bus.digit_blank), 32'd1);
            chk("rst_nibble", 32'(bus.digit_nibble), 32'd0);
        end
        bus.load = 1'b0;
        rst_n    = 1'b1;
        cycle();
        chk("rel_anode", 32'(bus.anode_n), 32'hE);
        chk("rel_nibble", 32'(bus.digit_nibble), 32'd0);

        // 2: basic load and scan
        load_now(16'h1A3F);
        wait_tick();
        cycle();
        for (int k = 1; k < FRAME; k++) begin
            cycle();
            if (k % RD == 0) chk("scan_gap", 32'(bus.anode_n), 32'hF);
            else begin
                chk("scan_anode", 32'(bus.anode_n), 32'(anSeq[k / RD]));
                chk("scan_nibble", 32'(bus.digit_nibble), 32'(nibSeq[k / RD]));
            end
        end

        // 3: double buffering
        repeat (3) cycle();
        load_now(16'h1111);
        chk("db_pending", 32'(bus.pending), 32'd1);
        chk("db_old0", 32'(bus.digit_nibble), 32'hF);
        cycle();
        chk("db_old1", 32'(bus.digit_nibble), 32'h3);
        wait_tick();
        chk("db_pend_hold", 32'(bus.pending), 32'd1);
        cycle();
        chk("db_pend_clr", 32'(bus.pending), 32'd0);
        for (int k = 1; k < FRAME; k++) begin
            cycle();
            if (k % RD != 0) chk("db_new", 32'(bus.digit_nibble), 32'h1);
        end

        // 4: collision and overwrite
        repeat (2) cycle();
        load_now(16'h2222);
        wait_tick();
        load_now(16'h3333);
        chk("col_pending", 32'(bus.pending), 32'd0);
        for (int k = 1; k < FRAME; k++) begin
            cycle();
            if (k % RD != 0) chk("col_nibble", 32'(bus.digit_nibble), 32'h3);
        end

        // 5: leading-zero blanking
        bus.blank_lz = 1'b1;
        load_now(16'h0050);
        for (int k = 1; k < FRAME; k++) begin
            cycle();
            if (k % RD != 0) chk("lz_0050", 32'(bus.digit_blank), 32'(k / RD >= 2));
        end
        load_now(16'h0000);
        for (int k = 1; k < FRAME; k++) begin
            cycle();
            if (k % RD != 0) chk("lz_0000", 32'(bus.digit_blank), 32'(k / RD != 0));
        end
        bus.blank_lz = 1'b0;

        // 6: decimal point, then reset mid-scan with a load pending
        bus.dp_in = 4'b0100;
        load_now(16'h5678);
        for (int k = 1; k < FRAME; k++) begin
            cycle();
            chk("dp", 32'(bus.dp_n), 32'(!(k / RD == 2 && k % RD != 0)));
        end
        cycle();
        load_now(16'h4321);
        chk("mr_pending", 32'(bus.pending), 32'd1);
        repeat (8) cycle();
        chk("mr_idx2", 32'(bus.anode_n), 32'hB);
        rst_n = 1'b0;
        cycle();
        chk("mr_anode", 32'(bus.anode_n), 32'hF);
        chk("mr_dp", 32'(bus.dp_n), 32'd1);
        chk("mr_pend", 32'(bus.pending), 32'd0);
        chk("mr_tick", 32'(bus.frame_tick), 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("mr_rel_anode", 32'(bus.anode_n), 32'hE);
        chk("mr_rel_nibble", 32'(bus.digit_nibble), 32'd0);
        wait_tick();
        cycle();
        chk("mr_no_stale", 32'(bus.digit_nibble), 32'd0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            bus.load     = bus.frame_tick ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
            bus.value_in = 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.dp_in = 4'($urandom);
            cycle();
        end
        bus.load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
